// File: rtl/gemm_reader_pkg.sv
// gemm_reader_pkg: reader FSM states and element packing defaults shared with the accelerator top
package gemm_reader_pkg;
    localparam int ELEM_WIDTH = 32;
    localparam int ELEMS_PER_WORD = 16;
    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_t;
endpackage

// File: rtl/gemm_result_reader_if.sv
// gemm_result_reader_if: C-memory read port plus element stream between reader and its neighbours
interface gemm_result_reader_if #(
    parameter int ElemWidth = 32,
    parameter int ElemsPerWord = 16,
    parameter int AddrWidth = 12
);
    logic [AddrWidth-1:0] sram_addr_o;
    logic [ElemsPerWord*ElemWidth-1:0] sram_rdata_i;
    logic m_valid_o;
    logic m_ready_i;
    logic [ElemWidth-1:0] m_data_o;
    logic m_last_o;
    modport master (output sram_addr_o, m_valid_o, m_data_o, m_last_o, input sram_rdata_i, m_ready_i);
    modport slave (input sram_addr_o, m_valid_o, m_data_o, m_last_o, output sram_rdata_i, m_ready_i);
endinterface

// File: rtl/result_word_buffer.sv
// result_word_buffer: current/prefetch word registers, element walk and stream outputs
module result_word_buffer #(
    parameter int ElemWidth = 32,
    parameter int ElemsPerWord = 16,
    parameter int SizeAddrWidth = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load,
    input  logic [SizeAddrWidth-1:0] num_elems,
    input  logic rvalid,
    input  logic [ElemsPerWord*ElemWidth-1:0] rdata,
    input  logic m_ready,
    output logic m_valid,
    output logic [ElemWidth-1:0] m_data,
    output logic m_last,
    output logic pf_valid,
    output logic last_hs
);
    localparam int IdxWidth = $clog2(ElemsPerWord);
    logic [ElemsPerWord*ElemWidth-1:0] cur, pf;
    logic cur_valid, hs, word_end, advance;
    logic [IdxWidth-1:0] idx;
    logic [SizeAddrWidth-1:0] left;
    assign hs = cur_valid && m_ready;
    assign m_valid = cur_valid;
    assign m_last = cur_valid && left == SizeAddrWidth'(1);
    assign m_data = cur[idx*ElemWidth +: ElemWidth];
    assign word_end = idx == IdxWidth'(ElemsPerWord - 1) || m_last;
    assign advance = hs && word_end;
    assign last_hs = hs && m_last;
    // a word arriving while the current one retires goes straight to cur (bypass)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur <= '0;
            pf <= '0;
            cur_valid <= 1'b0;
            pf_valid <= 1'b0;
            idx <= '0;
            left <= '0;
        end else begin
            if (load) left <= num_elems;
            else if (hs) left <= left - SizeAddrWidth'(1);
            if (hs) idx <= word_end ? '0 : idx + IdxWidth'(1);
            if (rvalid) pf <= rdata;
            if (rvalid && (!cur_valid || advance)) begin
                cur <= rdata;
                cur_valid <= 1'b1;
            end else if (advance) begin
                cur <= pf;
                cur_valid <= pf_valid;
                pf_valid <= 1'b0;
            end
            if (rvalid && cur_valid && !advance) pf_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/gemm_result_reader.sv
// gemm_result_reader: streams a contiguous region of the packed C memory out element by element
module gemm_result_reader
    import gemm_reader_pkg::*;
#(
    parameter int ElemWidth = ELEM_WIDTH,
    parameter int ElemsPerWord = ELEMS_PER_WORD,
    parameter int AddrWidth = 12,
    parameter int SizeAddrWidth = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [SizeAddrWidth-1:0] num_elems_i,
    output logic busy_o,
    output logic done_o,
    gemm_result_reader_if.master m
);
    state_t state, state_nxt;
    logic [AddrWidth-1:0] addr;
    logic [SizeAddrWidth-1:0] words_left, words_in;
    logic pending, rd_issue, pf_valid, last_hs, accept;
    assign accept = state == IDLE && start_i;
    assign words_in = num_elems_i / SizeAddrWidth'(ElemsPerWord)
                    + SizeAddrWidth'(num_elems_i % SizeAddrWidth'(ElemsPerWord) != '0);
    // at most one word in flight and one parked, so the buffer can never overflow
    assign rd_issue = (state == FETCH || state == STREAM) && words_left != '0 && !pf_valid && !pending;
    assign busy_o = state != IDLE;
    assign done_o = state == FINISH;
    assign m.sram_addr_o = addr;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            addr <= '0;
            words_left <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            pending <= rd_issue;
            if (accept) begin
                addr <= base_addr_i;
                words_left <= words_in;
            end else if (rd_issue) begin
                addr <= addr + AddrWidth'(1);
                words_left <= words_left - SizeAddrWidth'(1);
            end
        end
    end
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE   ? (start_i ? (num_elems_i == '0 ? FINISH : FETCH) : IDLE)
                  : state == FETCH  ? (pending ? STREAM : FETCH)
                  : state == STREAM ? (last_hs ? FINISH : STREAM)
                  : IDLE;
    end
    result_word_buffer #(
        .ElemWidth(ElemWidth),
        .ElemsPerWord(ElemsPerWord),
        .SizeAddrWidth(SizeAddrWidth)
    ) u_buf (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .load(accept),
        .num_elems(num_elems_i),
        .rvalid(pending),
        .rdata(m.sram_rdata_i),
        .m_ready(m.m_ready_i),
        .m_valid(m.m_valid_o),
        .m_data(m.m_data_o),
        .m_last(m.m_last_o),
        .pf_valid(pf_valid),
        .last_hs(last_hs)
    );
endmodule

// File: tb/tb_gemm_result_reader.sv
// tb_gemm_result_reader: directed checks of the C read-back engine against a one-cycle SRAM model
module tb_gemm_result_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [31:0] num_elems = '0;
    logic busy, done;
    logic [511:0] mem [4096];
    int total = 0;
    int bad = 0;

    gemm_result_reader_if #(.ElemWidth(32), .ElemsPerWord(16), .AddrWidth(12)) bus ();

    gemm_result_reader #(.ElemWidth(32), .ElemsPerWord(16), .AddrWidth(12), .SizeAddrWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
        .num_elems_i(num_elems), .busy_o(busy), .done_o(done), .m(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.sram_rdata_i <= mem[bus.sram_addr_o];

    function automatic logic [31:0] val(input logic [11:0] a, input int j);
        return {8'hC5, 4'(j), 8'h00, a};
    endfunction

    function automatic logic [31:0] exp_beat(input logic [11:0] b, input int k);
        logic [11:0] a;
        a = b + 12'(k / 16);
        return val(a, k % 16);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // start pulse, then cycle-accurate checks up to the first valid element (cycle 3)
    task automatic go(input logic [11:0] b, input int n);
        base_addr = b;
        num_elems = n;
        start = 1'b1;
        tick;
        start = 1'b0;
        base_addr = 12'h555;
        num_elems = 7;
        chk("addr_c1", bus.sram_addr_o, b);
        chk("busy_c1", busy, 1);
        chk("valid_c1", bus.m_valid_o, 0);
        tick;
        chk("valid_c2", bus.m_valid_o, 0);
        tick;
        chk("valid_c3", bus.m_valid_o, 1);
    endtask

    task automatic stream(input logic [11:0] b, input int n, input bit rnd, input int rst_at,
                          output int beats, output int cycles, output logic [31:0] last_data);
        logic [31:0] hd;
        logic hl, stalled, finished;
        beats = 0;
        cycles = 0;
        stalled = 1'b0;
        finished = 1'b0;
        hd = '0;
        hl = 1'b0;
        last_data = '0;
        while (!finished && cycles < 3000 && !(rst_at >= 0 && beats == rst_at)) begin
            bus.m_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #0;
            if (stalled) begin
                chk("stall_valid", bus.m_valid_o, 1);
                chk("stall_data", bus.m_data_o, hd);
                chk("stall_last", bus.m_last_o, hl);
            end
            stalled = 1'b0;
            if (bus.m_valid_o && bus.m_ready_i) begin
                chk("beat_data", bus.m_data_o, exp_beat(b, beats));
                chk("beat_last", bus.m_last_o, beats == n - 1);
                last_data = bus.m_data_o;
                beats++;
                if (bus.m_last_o) finished = 1'b1;
            end else if (bus.m_valid_o) begin
                stalled = 1'b1;
                hd = bus.m_data_o;
                hl = bus.m_last_o;
            end
            tick;
            cycles++;
        end
        bus.m_ready_i = 1'b1;
        if (rst_at < 0) begin
            chk("stream_bound", cycles < 3000, 1);
            chk("done_after_last", done, 1);
            chk("beat_count", beats, n);
        end
    endtask

    initial begin
        int beats, cycles;
        logic [31:0] ld;
        for (int a = 0; a < 4096; a++)
            for (int j = 0; j < 16; j++)
                mem[a][j*32 +: 32] = val(12'(a), j);
        bus.m_ready_i = 1'b1;
        tick;
        tick;
        chk("rst_valid", bus.m_valid_o, 0);
        chk("rst_data", bus.m_data_o, 0);
        chk("rst_last", bus.m_last_o, 0);
        chk("rst_addr", bus.sram_addr_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick;

        // 1: full 64 elements, ready held high
        go(12'd0, 64);
        stream(12'd0, 64, 1'b0, -1, beats, cycles, ld);
        chk("t1_no_bubbles", cycles, 64);
        chk("t1_last_data", ld, 32'hC5F00003);
        chk("t1_reads", bus.sram_addr_o, 4);
        tick;
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);

        // 2: partial final word
        go(12'd0, 20);
        stream(12'd0, 20, 1'b0, -1, beats, cycles, ld);
        chk("t2_beat19", ld, 32'hC5300001);
        chk("t2_reads", bus.sram_addr_o, 2);
        tick;
        chk("t2_no_extra_valid", bus.m_valid_o, 0);

        // 3: random back-pressure
        go(12'd0, 64);
        stream(12'd0, 64, 1'b1, -1, beats, cycles, ld);
        chk("t3_last_data", ld, 32'hC5F00003);
        chk("t3_reads", bus.sram_addr_o, 4);
        tick;

        // 4: empty transfer
        num_elems = 0;
        base_addr = 12'd9;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("t4_done_c1", done, 1);
        chk("t4_busy_c1", busy, 1);
        chk("t4_valid_c1", bus.m_valid_o, 0);
        tick;
        chk("t4_busy_c2", busy, 0);
        chk("t4_done_c2", done, 0);
        chk("t4_valid_c2", bus.m_valid_o, 0);
        tick;

        // 5: address wrap
        go(12'd4094, 48);
        stream(12'd4094, 48, 1'b0, -1, beats, cycles, ld);
        chk("t5_last_data", ld, 32'hC5F00000);
        chk("t5_end_addr", bus.sram_addr_o, 1);
        tick;

        // 6: reset mid-transfer, then restart with ignored start pulses
        go(12'd0, 64);
        stream(12'd0, 64, 1'b0, 10, beats, cycles, ld);
        chk("t6_beats_before_rst", beats, 10);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", bus.m_valid_o, 0);
        chk("t6_rst_last", bus.m_last_o, 0);
        chk("t6_rst_data", bus.m_data_o, 0);
        chk("t6_rst_addr", bus.sram_addr_o, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        tick;
        tick;
        chk("t6_rst_hold_valid", bus.m_valid_o, 0);
        rst = 1'b0;
        tick;
        go(12'd0, 40);
        base_addr = 12'd7;
        num_elems = 3;
        start = 1'b1;
        stream(12'd0, 40, 1'b0, -1, beats, cycles, ld);
        start = 1'b0;
        chk("t6_reads", bus.sram_addr_o, 3);
        tick;
        chk("t6_start_at_done_ignored", busy, 0);
        chk("t6_idle_addr", bus.sram_addr_o, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
